// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: bank FSM encoding, address
// decode positions and the idle (reset) levels of the SRAM pins.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } bank_state_e;

    // Byte address bit that picks ExtRAM (1) over BaseRAM (0)
    localparam int BANK_SEL_BIT = 22;

    // Byte address slice that forms the 20-bit SRAM word address
    localparam int WADDR_HI = 21;
    localparam int WADDR_LO = 2;

    // Pin levels while a bank is idle or held in reset
    localparam logic [3:0] BE_N_IDLE = 4'hF;
    localparam logic       CTRL_N_IDLE = 1'b1;

endpackage

// File: rtl/sram_bank_ctrl.sv
// One SRAM bank access engine: arbitrates between the fetch and data ports
// for this bank, runs IDLE -> ACCESS (WAIT_CYCLES) -> DONE, and drives the
// bank's registered control pins and tri-state data bus.
module sram_bank_ctrl
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_inst_req,
    input  logic [19:0] i_inst_addr,
    input  logic        i_data_req,
    input  logic [3:0]  i_data_we,
    input  logic [19:0] i_data_addr,
    input  logic [31:0] i_data_wdata,
    output logic        o_inst_ready,
    output logic        o_data_ready,
    output logic [31:0] o_rdata,
    inout  wire  [31:0] io_ram_data,
    output logic [19:0] o_ram_addr,
    output logic [3:0]  o_ram_be_n,
    output logic        o_ram_ce_n,
    output logic        o_ram_oe_n,
    output logic        o_ram_we_n
);

    localparam logic [2:0] CNT_LOAD = 3'(WAIT_CYCLES - 1);

    bank_state_e r_state;
    bank_state_e w_next;
    logic [2:0]  r_cnt;
    logic        r_last_data;   // last grant went to data; also owner of current access
    logic [3:0]  r_we;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_drv;
    logic [3:0]  w_nxt_we;
    logic        w_nxt_write;
    logic        w_grant_data;
    logic        w_start;
    logic        w_sample;

    // Data wins unless it also won last time and fetch is waiting
    assign w_grant_data = i_data_req && !(r_last_data && i_inst_req);
    assign w_start      = (r_state == ST_IDLE) && (i_inst_req || i_data_req);
    assign w_sample     = (r_state == ST_ACCESS) && (r_cnt == 3'd0);
    assign w_nxt_write  = |w_nxt_we;

    // Next-state and next access type (write strobes of the access about to run)
    always_comb begin
        w_next   = r_state;
        w_nxt_we = r_we;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next   = ST_ACCESS;
                    w_nxt_we = w_grant_data ? i_data_we : 4'h0;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == 3'd0) w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State, counter, grant history and registered SRAM pins
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_last_data <= 1'b0;
            r_we        <= 4'h0;
            o_ram_addr  <= 20'h0;
            o_ram_be_n  <= BE_N_IDLE;
            o_ram_ce_n  <= CTRL_N_IDLE;
            o_ram_oe_n  <= CTRL_N_IDLE;
            o_ram_we_n  <= CTRL_N_IDLE;
            r_drv       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_cnt       <= CNT_LOAD;
                r_last_data <= w_grant_data;
                r_we        <= w_nxt_we;
                o_ram_addr  <= w_grant_data ? i_data_addr : i_inst_addr;
            end else if ((r_state == ST_ACCESS) && (r_cnt != 3'd0)) begin
                r_cnt <= r_cnt - 3'd1;
            end
            o_ram_ce_n <= !(w_next == ST_ACCESS);
            o_ram_oe_n <= !((w_next == ST_ACCESS) && !w_nxt_write);
            o_ram_we_n <= !((w_next == ST_ACCESS) && w_nxt_write);
            o_ram_be_n <= (w_next == ST_ACCESS) ? (w_nxt_write ? ~w_nxt_we : 4'h0) : BE_N_IDLE;
            // Write data stays on the bus through DONE for hold time
            r_drv      <= ((w_next == ST_ACCESS) || (w_next == ST_DONE)) && w_nxt_write;
        end
    end

    // Write data latch and read data capture at the end of the last wait cycle
    always_ff @(posedge i_clk) begin
        if (w_start) r_wdata <= i_data_wdata;
        if (w_sample && (r_we == 4'h0)) r_rdata <= io_ram_data;
    end

    assign io_ram_data  = r_drv ? r_wdata : 32'bz;
    assign o_inst_ready = (r_state == ST_DONE) && !r_last_data;
    assign o_data_ready = (r_state == ST_DONE) && r_last_data;
    assign o_rdata      = ((r_state == ST_DONE) && (r_we == 4'h0)) ? r_rdata : 32'h0;

endmodule

// File: rtl/sram_arbiter.sv
// Shares BaseRAM and ExtRAM between the CPU fetch and data ports. Decodes
// each request to a bank, runs one access engine per bank, and muxes the
// completion pulse and read data back to the requesting port.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ready,
    input  logic        data_req,
    input  logic [3:0]  data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ready,
    inout  wire  [31:0] base_ram_data,
    output logic [19:0] base_ram_addr,
    output logic [3:0]  base_ram_be_n,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n,
    inout  wire  [31:0] ext_ram_data,
    output logic [19:0] ext_ram_addr,
    output logic [3:0]  ext_ram_be_n,
    output logic        ext_ram_ce_n,
    output logic        ext_ram_oe_n,
    output logic        ext_ram_we_n
);

    logic        w_inst_ext;
    logic        w_data_ext;
    logic [19:0] w_inst_waddr;
    logic [19:0] w_data_waddr;
    logic        w_b_inst_rdy, w_b_data_rdy, w_e_inst_rdy, w_e_data_rdy;
    logic [31:0] w_b_rdata, w_e_rdata;
    logic        w_unused_addr_bits;

    assign w_inst_ext   = inst_addr[BANK_SEL_BIT];
    assign w_data_ext   = data_addr[BANK_SEL_BIT];
    assign w_inst_waddr = inst_addr[WADDR_HI:WADDR_LO];
    assign w_data_waddr = data_addr[WADDR_HI:WADDR_LO];
    assign w_unused_addr_bits = ^{inst_addr[31:23], inst_addr[1:0],
                                  data_addr[31:23], data_addr[1:0]};

    sram_bank_ctrl #(.WAIT_CYCLES(WAIT_CYCLES)) u_base (
        .i_clk        (clk),
        .i_resetn     (resetn),
        .i_inst_req   (inst_req && !w_inst_ext),
        .i_inst_addr  (w_inst_waddr),
        .i_data_req   (data_req && !w_data_ext),
        .i_data_we    (data_we),
        .i_data_addr  (w_data_waddr),
        .i_data_wdata (data_wdata),
        .o_inst_ready (w_b_inst_rdy),
        .o_data_ready (w_b_data_rdy),
        .o_rdata      (w_b_rdata),
        .io_ram_data  (base_ram_data),
        .o_ram_addr   (base_ram_addr),
        .o_ram_be_n   (base_ram_be_n),
        .o_ram_ce_n   (base_ram_ce_n),
        .o_ram_oe_n   (base_ram_oe_n),
        .o_ram_we_n   (base_ram_we_n)
    );

    sram_bank_ctrl #(.WAIT_CYCLES(WAIT_CYCLES)) u_ext (
        .i_clk        (clk),
        .i_resetn     (resetn),
        .i_inst_req   (inst_req && w_inst_ext),
        .i_inst_addr  (w_inst_waddr),
        .i_data_req   (data_req && w_data_ext),
        .i_data_we    (data_we),
        .i_data_addr  (w_data_waddr),
        .i_data_wdata (data_wdata),
        .o_inst_ready (w_e_inst_rdy),
        .o_data_ready (w_e_data_rdy),
        .o_rdata      (w_e_rdata),
        .io_ram_data  (ext_ram_data),
        .o_ram_addr   (ext_ram_addr),
        .o_ram_be_n   (ext_ram_be_n),
        .o_ram_ce_n   (ext_ram_ce_n),
        .o_ram_oe_n   (ext_ram_oe_n),
        .o_ram_we_n   (ext_ram_we_n)
    );

    // Return the completion and read data from whichever bank finished for each port
    always_comb begin
        inst_ready = w_b_inst_rdy || w_e_inst_rdy;
        data_ready = w_b_data_rdy || w_e_data_rdy;
        inst_rdata = 32'h0;
        data_rdata = 32'h0;
        if (w_b_inst_rdy)      inst_rdata = w_b_rdata;
        else if (w_e_inst_rdy) inst_rdata = w_e_rdata;
        if (w_b_data_rdy)      data_rdata = w_b_rdata;
        else if (w_e_data_rdy) data_rdata = w_e_rdata;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the two off-chip SRAM banks (BaseRAM, ExtRAM) between the CPU's instruction-fetch port and data-access port. It decodes each request to a bank, arbitrates per bank, and drives the asynchronous SRAM control pins through a fixed-wait-state access sequence. The two banks run independent access engines, so one fetch and one data access may proceed in parallel when they target different banks. It sits between the IF/MEM stages and the board SRAM pins in `mycpu_top`.

## Interface
- `WAIT_CYCLES`, 2: cycles that ce_n/oe_n or we_n stay asserted per access, legal range 1..7.
- `clk`  in  1  system clock.
- `resetn`  in  1  reset, asynchronous and active-low.
- `inst_req`  in  1  fetch request. Held until `inst_ready`.
- `inst_addr`  in  32  fetch byte address.
- `inst_rdata`  out  32  fetch data. Valid while `inst_ready`=1.
- `inst_ready`  out  1  one-cycle completion pulse.
- `data_req`  in  1  data request. Held until `data_ready`.
- `data_we`  in  4  byte write strobes. 0 means read.
- `data_addr`  in  32  data byte address.
- `data_wdata`  in  32  store data.
- `data_rdata`  out  32  load data. Valid while `data_ready`=1.
- `data_ready`  out  1  one-cycle completion pulse.
- `base_ram_data`  inout  32  BaseRAM data bus.
- `base_ram_addr`  out  20  BaseRAM word address.
- `base_ram_be_n`, `base_ram_ce_n`, `base_ram_oe_n`, `base_ram_we_n`  out  4/1/1/1  BaseRAM byte enables, chip select, read enable, write enable (all active-low).
- `ext_ram_*`  same set as `base_ram_*` for ExtRAM.

## Operation
- Bank decode:
  - `addr[22]`=0 selects BaseRAM. `addr[22]`=1 selects ExtRAM.
  - SRAM word address = `addr[21:2]`.
  - Bits [31:23] and [1:0] are ignored.
- Fetches are always reads. A data request with `data_we`=0 is a read. Any nonzero `data_we` is a write.
- Per-bank FSM has three states: IDLE, ACCESS, DONE.
  - IDLE: if any request targets this bank, grant one, latch its addr/we/wdata, load the wait counter with `WAIT_CYCLES`-1, go to ACCESS.
  - ACCESS:
    - ce_n=0.
    - Read: oe_n=0, be_n=4'b0000.
    - Write: we_n=0, be_n=~we, data bus driven with the latched wdata.
    - The counter decrements each cycle. At 0, a read samples the data bus into that bank's rdata register. Then go to DONE.
  - DONE:
    - ce_n, oe_n and we_n are all 1.
    - A write keeps driving the data bus, for hold time.
    - The granted port's ready is 1 and its rdata is the sampled word.
    - Next state is IDLE.
- Arbitration, per bank:
  - Data wins over inst by default.
  - If the previous grant on that bank went to data and inst is pending on the same bank, inst wins. This prevents starvation.
- Each port has at most one request in flight. A port never receives two grants at once.
- Output muxing: `inst_ready`/`inst_rdata` come from whichever bank currently holds the inst grant in DONE, else 0. The data port is muxed the same way.
- Data bus is tri-stated except during ACCESS and DONE of a write.
- Requester rules:
  - Hold req and all fields stable until ready.
  - req may be deasserted in the ready cycle, or a new request presented in the following cycle.
  - Changing fields mid-access is unsupported. The latched values are used.
- Reset (asynchronous, including mid-access):
  - FSMs go to IDLE and the arbitration history is cleared.
  - All ce_n/oe_n/we_n = 1, be_n = 4'hF, addr = 0.
  - Buses are tri-stated.
  - `inst_ready`/`data_ready` = 0, rdata outputs = 0.
  - In-flight requests are dropped and must be reissued after reset.

## Timing
- Request first seen in IDLE in cycle 0 → SRAM pins asserted in cycles 1..W (W=`WAIT_CYCLES`) → ready in cycle W+1.
  - A read samples the bus on the clk edge that ends cycle W.
- Throughput per bank: one access per W+2 cycles (IDLE, W×ACCESS, DONE).
- All SRAM pin outputs are registered, so there are no combinational paths from request inputs to pins.
- When both ports target different banks in the same cycle, both complete in the same cycle W+1.

## Structure
- Shared package holds:
  - the FSM state encoding;
  - bank-select bit index (22);
  - word-address slice [21:2];
  - the reset pin values (be_n=4'hF, controls=1).
- One sub-module, `sram_bank_ctrl`, instantiated twice. It contains the per-bank FSM, wait counter, latches, tri-state driver and arbitration-history bit.
- The top does bank decode and the ready/rdata return muxing.

## Test plan
- **Single fetch read.** W=2, inst read of 0x8000_0010, BaseRAM model returns 0x1234_5678 → base_ram_addr=0x00004, oe_n low in cycles 1–2, `inst_ready` in cycle 3 with `inst_rdata`=0x1234_5678.
- **Byte store.** `data_we`=4'b0010, addr 0x8040_0008, wdata 0xAABB_CCDD → ext_ram_be_n=4'b1101, we_n low for 2 cycles, bus driven through DONE, `data_ready` in cycle 3, BaseRAM untouched.
- **Same-bank conflict.** Inst and data both request BaseRAM in the same cycle → data completes in cycle 3, inst in cycle 7.
- **Repeated data requests with inst waiting.** Data reissues immediately while inst stays pending on the same bank → grants alternate data, inst, data.
- **Different-bank parallel access.** Inst to 0x8000_0000, data read of 0x8040_0000 in the same cycle → both readies in cycle 3.
- **Reset mid-access.** Assert resetn=0 in cycle 2 of a write → all control pins high and buses high-Z immediately, no ready pulse. A request reissued after release completes normally.
